// File: rtl/bitlet_bit_scheduler.sv
// bitlet_bit_scheduler: serialises an essential-bit mask into one beat per set bit, lowest bit first.
module bitlet_onehot_dec #(
  parameter int W = 16
) (
  input  logic [$clog2(W)-1:0] idx,
  input  logic                 en,
  output logic [W-1:0]         onehot
);
  always_comb onehot = en ? W'(1) << idx : '0;
endmodule

module bitlet_bit_scheduler #(
  parameter int W  = 16,
  parameter int TW = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   IN_VLD,
  output logic                   IN_RDY,
  input  logic [W-1:0]           IN_MASK,
  input  logic [TW-1:0]          IN_TAG,
  output logic                   OUT_VLD,
  input  logic                   OUT_RDY,
  output logic [$clog2(W)-1:0]   OUT_IDX,
  output logic [W-1:0]           OUT_ONEHOT,
  output logic [TW-1:0]          OUT_TAG,
  output logic                   OUT_LAST,
  output logic                   OUT_ZERO,
  output logic [$clog2(W):0]     OUT_CNT
);
  localparam int IW = $clog2(W);
  localparam int CW = IW + 1;
  localparam logic [W-1:0] one_w = W'(1);
  localparam logic [CW-1:0] one_c = CW'(1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zf_q, zf_d;
  logic [IW-1:0] low_idx;
  logic run, single, accept, step, done;
  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = accept ? RUN : done ? IDLE : state_q;
  // scanning downward leaves the lowest set bit as the final winner
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) if (rem_q[i]) low_idx = IW'(i);
  end
  always_comb begin
    run      = state_q == RUN;
    single   = rem_q != '0 && (rem_q & (rem_q - one_w)) == '0;
    OUT_VLD  = run;
    OUT_IDX  = zf_q ? '0 : low_idx;
    OUT_LAST = run && (zf_q || single);
    OUT_ZERO = run && zf_q;
    OUT_TAG  = tag_q;
    OUT_CNT  = cnt_q;
    IN_RDY   = !run || (OUT_LAST && OUT_RDY);
    accept   = IN_VLD && IN_RDY;
    step     = run && OUT_RDY && !OUT_LAST;
    done     = run && OUT_RDY && OUT_LAST;
  end
  bitlet_onehot_dec #(.W(W)) u_dec (
    .idx   (OUT_IDX),
    .en    (run && !zf_q),
    .onehot(OUT_ONEHOT)
  );
  always_comb begin
    rem_d = accept ? IN_MASK : step ? rem_q & ~OUT_ONEHOT : done ? '0 : rem_q;
    tag_d = accept ? IN_TAG : tag_q;
    cnt_d = accept ? '0 : step ? cnt_q + one_c : cnt_q;
    zf_d  = accept ? IN_MASK == '0 : zf_q;
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rem_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      zf_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      zf_q  <= zf_d;
    end
  end
endmodule

// File: doc/bitlet_bit_scheduler.md
BITLET_BIT_SCHEDULER -- requirements
Module: Bitlet_Bit_Scheduler

Interface
REQ-001 Parameter W, default 16; width of the essential-bit mask and of the one-hot output; power of two, 2 to 64.
REQ-002 Parameter TW, default 4; width of the sideband tag carried with each mask.
REQ-003 Port CLK, input, 1; single clock, all state updates on the rising edge.
REQ-004 Port RSTN, input, 1; reset, synchronous, active-low.
REQ-005 Port IN_VLD, input, 1; a mask word is offered.
REQ-006 Port IN_RDY, output, 1; the scheduler accepts the offered word this cycle.
REQ-007 Port IN_MASK, input, W; essential-bit mask, bit i set means bit position i must be processed.
REQ-008 Port IN_TAG, input, TW; sideband identifier, returned with every beat of the word.
REQ-009 Port OUT_VLD, output, 1; a scheduled beat is presented.
REQ-010 Port OUT_RDY, input, 1; the downstream PE consumes the beat.
REQ-011 Port OUT_IDX, output, $clog2(W); binary index of the scheduled bit.
REQ-012 Port OUT_ONEHOT, output, W; one-hot form of OUT_IDX; all zero on a zero-word beat.
REQ-013 Port OUT_TAG, output, TW; tag of the word being scheduled.
REQ-014 Port OUT_LAST, output, 1; final beat of the current word.
REQ-015 Port OUT_ZERO, output, 1; the current word had an all-zero mask.
REQ-016 Port OUT_CNT, output, $clog2(W)+1; ordinal of this beat within its word, starting at 0.

Function
REQ-017 The FSM has two states, IDLE and RUN, plus registers REM (W bits), TAG (TW bits), CNT and ZF (zero flag).
REQ-018 IDLE: IN_RDY=1 and OUT_VLD=0; on IN_VLD, load REM=IN_MASK, TAG=IN_TAG, CNT=0 and ZF=(IN_MASK==0), then go to RUN.
REQ-019 RUN: OUT_VLD=1; OUT_IDX is the lowest set bit of REM, or 0 if ZF; OUT_ONEHOT = 1<<OUT_IDX when ZF=0, else 0.
REQ-020 OUT_LAST=1 when ZF=1 or when REM has exactly one bit set; OUT_ZERO=ZF; OUT_TAG=TAG; OUT_CNT=CNT.
REQ-021 RUN with OUT_RDY=1 and OUT_LAST=0: clear the scheduled bit (REM &= ~OUT_ONEHOT), increment CNT and stay in RUN.
REQ-022 RUN with OUT_RDY=0: hold all state; every OUT_* signal stays stable until the beat is consumed.
REQ-023 IN_RDY = (state==IDLE) or (state==RUN and OUT_LAST and OUT_RDY); IN_RDY never depends combinationally on IN_VLD.
REQ-024 When the last beat is consumed and IN_VLD=1 in the same cycle, load the new word and stay in RUN with no idle bubble.
REQ-025 When the last beat is consumed and IN_VLD=0, go to IDLE and clear REM.
REQ-026 Latency: a word accepted at edge k presents its first beat in the cycle after edge k.
REQ-027 Throughput: one beat per cycle under OUT_RDY=1; a word with N set bits takes max(N,1) beats.
REQ-028 Beats are issued in strictly ascending bit order; each set bit is issued exactly once; no beat is issued for a clear bit.
REQ-029 IN_MASK and IN_TAG are sampled only on an accepted cycle; changes while IN_RDY=0 have no effect.
REQ-030 The binary-to-one-hot step uses the codebase one-hot decoder primitive with width W.

Reset
REQ-031 When RSTN=0 at a rising edge: state=IDLE and REM, TAG, CNT, ZF are all 0.
REQ-032 During reset, the next cycle shows IN_RDY=1, OUT_VLD=0, OUT_LAST=0, OUT_ZERO=0, OUT_IDX=0, OUT_ONEHOT=0, OUT_TAG=0 and OUT_CNT=0.
REQ-033 Reset during RUN discards the in-flight word; no further beats of that word are issued.

Verification
REQ-034 W=16, IN_MASK=16'h8421, tag 3, OUT_RDY=1 -> 4 consecutive beats: IDX 0,5,10,15; CNT 0..3; LAST only on IDX 15; tag 3 on every beat.
REQ-035 IN_MASK=0 -> 1 beat with OUT_ZERO=1, OUT_LAST=1, OUT_ONEHOT=0, OUT_IDX=0.
REQ-036 IN_MASK=16'hFFFF, OUT_RDY toggling 1,0,1,0 -> 16 beats, each held stable while stalled; IDX 0..15 with none skipped or repeated.
REQ-037 Back-to-back words 16'h0003 then 16'h8000, IN_VLD held high -> beats IDX 0,1,15 on 3 consecutive cycles; IN_RDY=1 on the cycle IDX 1 is consumed.
REQ-038 RSTN=0 asserted on the second beat of 16'h00F0 -> next cycle OUT_VLD=0 and IN_RDY=1; the next word's first beat has CNT=0.
REQ-039 Random masks with random OUT_RDY backpressure -> the OR of consumed OUT_ONEHOT equals IN_MASK per word, and the beat count equals max(popcount,1).
